// File: rtl/tick_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tick_sched_ctrl
// Purpose  : Programmable tick scheduler. It divides clk_fpga into one-cycle
//            enable pulses (tick) at a runtime-configured period. A
//            start/pause/stop sequencer runs the scheduler in one of two ways:
//            free-running, or for N ticks followed by a done pulse.
// Options  : SLOW_CLK_OUT_EN - when defined, adds the clk_slow square-wave
//            output. clk_slow toggles on every tick.
// Revision : 1.0 - initial release
// ============================================================================
module tick_sched_ctrl #(
    parameter int               DIV_W         = 24,
    parameter int               CNT_W         = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV   = 24'd9_999_999,
    parameter logic [CNT_W-1:0] DEFAULT_COUNT = 16'd0
) (
    input  logic             clk_fpga,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state
`ifdef SLOW_CLK_OUT_EN
    ,
    output logic             clk_slow
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_prescaler;
    logic [CNT_W-1:0] r_remaining;
    logic             r_tick;
    logic             r_done;

    logic             w_idle;
    logic             w_active;
    logic             w_cfg_fire;
    logic             w_start;
    logic             w_abort;
    logic             w_advance;
    logic             w_terminal;
    logic             w_counted;
    logic             w_last;

    // State register; an asynchronous reset aborts any run without emitting done.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and sequencing controls. Stop outranks everything, and pause
    // freezes the prescaler on the same edge it is first seen, even from RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_idle      = (r_state == ST_IDLE);
        w_active    = !w_idle;
        w_cfg_fire  = cfg_valid && w_idle;
        w_start     = start && w_idle;
        w_abort     = stop && w_active;
        w_advance   = w_active && !stop && !pause;
        w_terminal  = w_advance && (r_prescaler == r_div);
        w_counted   = (r_cnt != '0);
        w_last      = w_terminal && w_counted && (r_remaining == CNT_W'(1));

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else if (pause) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else if (!pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Configuration registers; loaded only while idle so a run never sees a change.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= DEFAULT_DIV;
            r_cnt <= DEFAULT_COUNT;
        end else if (w_cfg_fire) begin
            r_div <= cfg_div;
            r_cnt <= cfg_count;
        end
    end

    // Prescaler: clears on start, stop and terminal count; holds while paused.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= '0;
        end else if (w_start || w_abort || w_terminal) begin
            r_prescaler <= '0;
        end else if (w_advance) begin
            r_prescaler <= r_prescaler + DIV_W'(1);
        end
    end

    // Tick budget. A config accepted with start takes effect for this run.
    // The budget is kept after stop so software can read back the residue.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
        end else if (w_start) begin
            r_remaining <= w_cfg_fire ? cfg_count : r_cnt;
        end else if (w_terminal && w_counted) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // Registered one-cycle pulses; done coincides with the final counted tick.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tick <= w_terminal;
            r_done <= w_last;
        end
    end

`ifdef SLOW_CLK_OUT_EN
    logic r_clk_slow;

    // Legacy square wave: flips on each tick and holds while idle or paused.
    // It is fabric data, not a clock net.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_slow <= 1'b0;
        end else if (w_terminal) begin
            r_clk_slow <= ~r_clk_slow;
        end
    end

    assign clk_slow = r_clk_slow;
`endif

    assign cfg_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign tick      = r_tick;
    assign done      = r_done;
    assign remaining = r_remaining;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tick_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_sched_ctrl
// Purpose  : Directed self-checking bench for tick_sched_ctrl. It uses a
//            shortened default period (DEFAULT_DIV = 9).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_sched_ctrl;

    logic        clk_fpga;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_div;
    logic [15:0] cfg_count;
    logic        start;
    logic        pause;
    logic        stop;
    logic        tick;
    logic        done;
    logic        busy;
    logic [15:0] remaining;
    logic [1:0]  state;
`ifdef SLOW_CLK_OUT_EN
    logic        clk_slow;
    logic        slow_ref;
`endif

    int tests;
    int fails;
    logic [20:0] tmask;
    logic [20:0] dmask;

    tick_sched_ctrl #(
        .DIV_W         (24),
        .CNT_W         (16),
        .DEFAULT_DIV   (24'd9),
        .DEFAULT_COUNT (16'd0)
    ) dut (
        .clk_fpga  (clk_fpga),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_count (cfg_count),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .tick      (tick),
        .done      (done),
        .busy      (busy),
        .remaining (remaining),
        .state     (state)
`ifdef SLOW_CLK_OUT_EN
        ,
        .clk_slow  (clk_slow)
`endif
    );

    initial begin
        clk_fpga = 1'b0;
        forever #5 clk_fpga = ~clk_fpga;
    end

    // Advance one rising edge, then settle 1 ns so that outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input logic [23:0] d, input logic [15:0] c);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_count = c;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_count = '0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        step();
        step();

        // ---- reset state ----
        chk("rst_state", state, 2'b00);
        chk("rst_tick", tick, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_remaining", remaining, 16'd0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
`ifdef SLOW_CLK_OUT_EN
        chk("rst_clk_slow", clk_slow, 1'b0);
`endif
        rst_n = 1'b1;
        step();

        // ---- 1: default period (9 -> every 10 cycles), free-run ----
        do_start();
        chk("t1_state_run", state, 2'b01);
        chk("t1_busy", busy, 1'b1);
        chk("t1_cfg_ready", cfg_ready, 1'b0);
        tmask = '0;
        dmask = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            tmask[i] = tick;
            dmask[i] = done;
        end
        chk("t1_ticks", tmask, 21'h100400);
        chk("t1_no_done", dmask, 21'h0);
        chk("t1_remaining", remaining, 16'd0);
        do_stop();
        chk("t1_stop_idle", state, 2'b00);
        chk("t1_stop_tick", tick, 1'b0);

        // ---- 2: div=3, count=5 ----
        load_cfg(24'd3, 16'd5);
        do_start();
        chk("t2_rem_start", remaining, 16'd5);
        tmask = '0;
        dmask = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            tmask[i] = tick;
            dmask[i] = done;
            if (i == 8) chk("t2_rem_after2", remaining, 16'd3);
        end
        chk("t2_ticks", tmask, 21'h111110);
        chk("t2_done", dmask, 21'h100000);
        chk("t2_rem_end", remaining, 16'd0);
        step();
        chk("t2_busy_after", busy, 1'b0);
        chk("t2_ready_after", cfg_ready, 1'b1);
        chk("t2_done_pulse", done, 1'b0);
        chk("t2_tick_after", tick, 1'b0);

        // ---- 3: div=3, free-run, pause 6 cycles at prescaler=2, pause on terminal ----
        load_cfg(24'd3, 16'd0);
        do_start();
        tmask = '0;
        for (int i = 1; i <= 16; i++) begin
            pause = ((i >= 3) && (i <= 8)) || ((i >= 14) && (i <= 15));
            step();
            tmask[i] = tick;
            if (i == 8) chk("t3_state_pause", state, 2'b10);
        end
        pause = 1'b0;
        chk("t3_ticks", tmask, 21'h010400);
        chk("t3_remaining", remaining, 16'd0);
        do_stop();

        // ---- 4: div=3, count=5, stop at the third terminal count ----
        load_cfg(24'd3, 16'd5);
        do_start();
        for (int i = 1; i <= 11; i++) step();
        chk("t4_rem_pre", remaining, 16'd3);
        do_stop();
        chk("t4_tick", tick, 1'b0);
        chk("t4_done", done, 1'b0);
        chk("t4_state", state, 2'b00);
        chk("t4_remaining", remaining, 16'd3);
        tmask = '0;
        for (int i = 1; i <= 6; i++) begin
            step();
            tmask[i] = tick;
        end
        chk("t4_quiet", tmask, 21'h0);

        // ---- 5: cfg ignored in RUN; cfg and start in the same cycle ----
        do_start();
        cfg_valid = 1'b1;
        cfg_div   = 24'd7;
        cfg_count = 16'd9;
        #1;
        chk("t5_ready_run", cfg_ready, 1'b0);
        step();
        step();
        cfg_valid = 1'b0;
        do_stop();
        do_start();
        tmask = '0;
        for (int i = 1; i <= 4; i++) begin
            step();
            tmask[i] = tick;
        end
        chk("t5_old_div", tmask, 21'h10);
        chk("t5_old_count", remaining, 16'd4);
        do_stop();
        cfg_valid = 1'b1;
        cfg_div   = 24'd1;
        cfg_count = 16'd2;
        start     = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        chk("t5_rem_new", remaining, 16'd2);
        tmask = '0;
        dmask = '0;
        for (int i = 1; i <= 4; i++) begin
            step();
            tmask[i] = tick;
            dmask[i] = done;
        end
        chk("t5_ticks", tmask, 21'h14);
        chk("t5_done", dmask, 21'h10);
        chk("t5_idle", state, 2'b00);

        // ---- 6: asynchronous reset mid-run ----
        load_cfg(24'd3, 16'd5);
        do_start();
        for (int i = 1; i <= 13; i++) begin
            step();
`ifdef SLOW_CLK_OUT_EN
            if (i == 3) slow_ref = clk_slow;
            if (i == 4) chk("t6_slow_toggle1", clk_slow, ~slow_ref);
            if (i == 7) chk("t6_slow_hold", clk_slow, ~slow_ref);
            if (i == 8) chk("t6_slow_toggle2", clk_slow, slow_ref);
`endif
        end
        chk("t6_rem_pre", remaining, 16'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_state", state, 2'b00);
        chk("t6_tick", tick, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_remaining", remaining, 16'd0);
        chk("t6_ready", cfg_ready, 1'b1);
`ifdef SLOW_CLK_OUT_EN
        chk("t6_slow_reset", clk_slow, 1'b0);
`endif
        step();
        rst_n = 1'b1;
        step();
        do_start();
        tmask = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            tmask[i] = tick;
        end
        chk("t6_default_div", tmask, 21'h400);
        do_stop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
